// File: rtl/biu_master_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by biu_master.
//
// bus_if        : shared tri-state bus between one master and a responder.
//                 Each agent presents its own drive value plus an output
//                 enable; the resolved nets (address, data, control) float
//                 to 'z whenever no agent drives them.
//                 control[1] = rnw, control[0] = data_valid.
//   modport master    : drives mst_*, observes the resolved bus
//   modport responder : drives rsp_*, observes the resolved bus
//
// biu_master_if : master-side request/response port of the BIU.
//   en, rnw, address, data_in           : request from the client
//   data_out, data_valid, busy, error   : response to the client
//   modport biu    : BIU view
//   modport client : client view
// ---------------------------------------------------------------------------
interface bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mst_oe;
    logic [ADDR_WIDTH-1:0] mst_address;
    logic [DATA_WIDTH-1:0] mst_data;
    logic [1:0]            mst_control;

    logic                  rsp_oe;
    logic [ADDR_WIDTH-1:0] rsp_address;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_control;

    // Resolved bus: multiple tri-state drivers need a net, not a variable.
    wire [ADDR_WIDTH-1:0]  address;
    wire [DATA_WIDTH-1:0]  data;
    wire [1:0]             control;

    assign address = mst_oe ? mst_address : 'z;
    assign data    = mst_oe ? mst_data    : 'z;
    assign control = mst_oe ? mst_control : 'z;

    assign address = rsp_oe ? rsp_address : 'z;
    assign data    = rsp_oe ? rsp_data    : 'z;
    assign control = rsp_oe ? rsp_control : 'z;

    modport master (
        output mst_oe, mst_address, mst_data, mst_control,
        input  address, data, control
    );

    modport responder (
        output rsp_oe, rsp_address, rsp_data, rsp_control,
        input  address, data, control
    );
endinterface

interface biu_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic                  rnw;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  error;

    modport biu (
        input  en, rnw, address, data_in,
        output data_out, data_valid, busy, error
    );

    modport client (
        output en, rnw, address, data_in,
        input  data_out, data_valid, busy, error
    );
endinterface

// File: rtl/biu_master.sv
// ---------------------------------------------------------------------------
// biu_master: single-outstanding bus interface unit (master side).
//
// Accepts one request from the client, places it on the shared tri-state
// bus for one cycle, then either allows one turnaround cycle (write) or
// waits for a matching read response with a bounded timeout.
//
// Parameters
//   ADDR_WIDTH     : bus / client address width
//   DATA_WIDTH     : bus / client data width
//   TIMEOUT_CYCLES : max WAIT_RSP cycles for a read response (1..65535)
//
// Ports
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : shared bus (master modport)
//   biu   : client request/response port (biu modport)
// ---------------------------------------------------------------------------
module biu_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic      clk,
    input  logic      n_rst,
    bus_if.master     bus,
    biu_master_if.biu biu
);

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        SEND_REQ = 5'b00010,
        WAIT_WR  = 5'b00100,
        WAIT_RSP = 5'b01000,
        DONE     = 5'b10000
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rnw_q;
    logic [15:0]           timeout_cnt;

    logic                  drive_q;
    logic                  busy_q;
    logic                  data_valid_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic                  rsp_match;

    assign rsp_match = bus.control[0] && bus.control[1] && (bus.address == address_q);

    // Drive values are always presented; only the enable decides ownership.
    assign bus.mst_oe      = drive_q;
    assign bus.mst_address = address_q;
    assign bus.mst_data    = wdata_q;
    assign bus.mst_control = {rnw_q, 1'b1};

    assign biu.data_out    = data_out_q;
    assign biu.data_valid  = data_valid_q;
    assign biu.busy        = busy_q;
    assign biu.error       = error_q;

    // Outputs are registered, so each is set on the transition into the
    // state in which it must be visible.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            address_q    <= '0;
            wdata_q      <= '0;
            rnw_q        <= 1'b0;
            timeout_cnt  <= '0;
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            data_out_q   <= '0;
        end else begin
            drive_q      <= 1'b0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (biu.en) begin
                        address_q <= biu.address;
                        wdata_q   <= biu.data_in;
                        rnw_q     <= biu.rnw;
                        drive_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= SEND_REQ;
                    end
                end
                SEND_REQ: begin
                    timeout_cnt <= '0;
                    state       <= rnw_q ? WAIT_RSP : WAIT_WR;
                end
                WAIT_WR: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                WAIT_RSP: begin
                    // Response is tested before timeout so it wins a tie.
                    if (rsp_match) begin
                        data_out_q   <= bus.data;
                        data_valid_q <= 1'b1;
                        state        <= DONE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_master.sv
// ---------------------------------------------------------------------------
// tb_biu_master: self-checking bench for biu_master (TIMEOUT_CYCLES = 4).
// Stimulus pushes expected bus requests and client responses into queues;
// a negedge monitor pops and compares whenever the DUT drives the bus or
// pulses data_valid / error.
// ---------------------------------------------------------------------------
module tb_biu_master;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  c;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] d;
    } rsp_t;

    logic clk;
    logic n_rst;

    int n_cmp = 0;
    int n_bad = 0;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t mon_req;
    rsp_t mon_rsp;

    bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_i ();
    biu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) biu_i ();

    biu_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus_i),
        .biu  (biu_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard side.
    always @(negedge clk) begin
        if (bus_i.mst_oe) begin
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got request addr %0h expected none (t=%0t)",
                         bus_i.address, $time);
            end else begin
                mon_req = exp_req.pop_front();
                check("req_address", 64'(bus_i.address), 64'(mon_req.a));
                check("req_data",    64'(bus_i.data),    64'(mon_req.d));
                check("req_control", 64'(bus_i.control), 64'(mon_req.c));
            end
        end
        if (biu_i.data_valid || biu_i.error) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got valid=%0b error=%0b expected none (t=%0t)",
                         biu_i.data_valid, biu_i.error, $time);
            end else begin
                mon_rsp = exp_rsp.pop_front();
                check("rsp_kind", 64'({biu_i.data_valid, biu_i.error}),
                      64'(mon_rsp.err ? 2'b01 : 2'b10));
                check("rsp_data", 64'(biu_i.data_out), 64'(mon_rsp.d));
            end
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 in SEND_REQ.
    task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] d);
        req_t q;
        q.a = a;
        q.d = d;
        q.c = {r, 1'b1};
        exp_req.push_back(q);
        biu_i.en      = 1'b1;
        biu_i.rnw     = r;
        biu_i.address = a;
        biu_i.data_in = d;
        @(posedge clk); #1;
        biu_i.en = 1'b0;
    endtask

    task automatic expect_rsp(input logic err, input logic [31:0] d);
        rsp_t e;
        e.err = err;
        e.d   = d;
        exp_rsp.push_back(e);
    endtask

    task automatic rsp_drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        bus_i.rsp_oe      = 1'b1;
        bus_i.rsp_control = c;
        bus_i.rsp_address = a;
        bus_i.rsp_data    = d;
        @(posedge clk); #1;
        bus_i.rsp_oe = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (biu_i.busy && i < 32) begin
            @(posedge clk); #1;
            i++;
        end
        check("reach_idle", 64'(biu_i.busy), 64'(0));
    endtask

    // Counts negedges with busy high, stopping at the first idle negedge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (biu_i.busy) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        n_rst             = 1'b0;
        biu_i.en          = 1'b0;
        biu_i.rnw         = 1'b0;
        biu_i.address     = '0;
        biu_i.data_in     = '0;
        bus_i.rsp_oe      = 1'b0;
        bus_i.rsp_address = '0;
        bus_i.rsp_data    = '0;
        bus_i.rsp_control = '0;

        // Reset state
        #12;
        check("rst_busy",       64'(biu_i.busy),       64'(0));
        check("rst_data_valid", 64'(biu_i.data_valid), 64'(0));
        check("rst_error",      64'(biu_i.error),      64'(0));
        check("rst_data_out",   64'(biu_i.data_out),   64'(0));
        check("rst_bus_oe",     64'(bus_i.mst_oe),     64'(0));
        #10 n_rst = 1'b1;
        @(posedge clk); #1;

        // Write: one request cycle, busy for 2 cycles, bus released after
        issue(1'b0, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_busy_send", 64'(biu_i.busy), 64'(1));
        @(negedge clk);
        check("wr_busy_turn", 64'(biu_i.busy), 64'(1));
        check("wr_bus_released", 64'(bus_i.mst_oe), 64'(0));
        @(negedge clk);
        check("wr_idle", 64'(biu_i.busy), 64'(0));
        check("wr_bus_released_idle", 64'(bus_i.mst_oe), 64'(0));
        @(posedge clk); #1;

        // Read: responder busy for 2 cycles, then answers
        expect_rsp(1'b0, 32'h12345678);
        issue(1'b1, 32'h104, 32'h0);
        @(posedge clk); #1;
        rsp_drive(2'b10, 32'h104, 32'hFFFF0000);
        rsp_drive(2'b10, 32'h104, 32'hFFFF0000);
        rsp_drive(2'b11, 32'h104, 32'h12345678);
        wait_idle();

        // Timeout: no responder; SEND_REQ + 4 WAIT_RSP cycles, data_out kept
        expect_rsp(1'b1, 32'h12345678);
        issue(1'b1, 32'h200, 32'h0);
        count_busy(n);
        check("timeout_busy_cycles", 64'(n), 64'(5));
        @(posedge clk); #1;

        // Response in the last allowed WAIT_RSP cycle wins over timeout
        expect_rsp(1'b0, 32'hA5A50F0F);
        issue(1'b1, 32'h300, 32'h0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rsp_drive(2'b11, 32'h300, 32'hA5A50F0F);
        wait_idle();

        // Address mismatch ignored, later match captured
        expect_rsp(1'b0, 32'hCAFEF00D);
        issue(1'b1, 32'h400, 32'h0);
        @(posedge clk); #1;
        rsp_drive(2'b11, 32'h404, 32'h0BAD0BAD);
        rsp_drive(2'b11, 32'h400, 32'hCAFEF00D);
        wait_idle();

        // en held high: no queuing, re-accept in the cycle busy falls
        begin
            req_t q;
            q.a = 32'h500; q.d = 32'h0; q.c = 2'b11;
            exp_req.push_back(q);
            biu_i.en = 1'b1; biu_i.rnw = 1'b1; biu_i.address = 32'h500; biu_i.data_in = 32'h0;
            @(posedge clk); #1;
            biu_i.address = 32'h508;
            q.a = 32'h508;
            exp_req.push_back(q);
            @(posedge clk); #1;
            expect_rsp(1'b0, 32'h11112222);
            rsp_drive(2'b11, 32'h500, 32'h11112222);
            @(posedge clk); #1;
            check("busy_falls", 64'(biu_i.busy), 64'(0));
            @(posedge clk); #1;
            biu_i.en = 1'b0;
            check("busy_reaccept", 64'(biu_i.busy), 64'(1));
            @(posedge clk); #1;
            expect_rsp(1'b0, 32'h33334444);
            rsp_drive(2'b11, 32'h508, 32'h33334444);
            wait_idle();
        end

        // Asynchronous reset during WAIT_RSP aborts with no pulse
        issue(1'b1, 32'h600, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 n_rst = 1'b0;
        #1;
        check("arst_busy",       64'(biu_i.busy),       64'(0));
        check("arst_data_valid", 64'(biu_i.data_valid), 64'(0));
        check("arst_error",      64'(biu_i.error),      64'(0));
        check("arst_data_out",   64'(biu_i.data_out),   64'(0));
        check("arst_bus_oe",     64'(bus_i.mst_oe),     64'(0));
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(biu_i.busy), 64'(0));

        check("exp_req_drained", 64'(exp_req.size()), 64'(0));
        check("exp_rsp_drained", 64'(exp_rsp.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000 (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/biu_master.md
BIU_MASTER -- requirements
Module: biu_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of bus and master-side address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of bus and master-side data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles spent waiting for a read response; legal range 1..2^16-1.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port bus, bus_if, shared tri-state bus: address, data, control[1]=rnw, control[0]=data_valid.
REQ-007 SHALL have port biu, biu_master_if.biu, master-side request/response interface, described in REQ-008 to REQ-014.
REQ-008 SHALL have biu.en, input, 1 bit, request strobe; sampled only in IDLE.
REQ-009 SHALL have biu.rnw, input, 1 bit, 1=read, 0=write.
REQ-010 SHALL have biu.address, input, ADDR_WIDTH, absolute target address.
REQ-011 SHALL have biu.data_in, input, DATA_WIDTH, write data.
REQ-012 SHALL have biu.data_out, output, DATA_WIDTH, last captured read data.
REQ-013 SHALL have biu.data_valid, output, 1 bit, one-cycle pulse: read data valid on biu.data_out.
REQ-014 SHALL have biu.busy, output, 1 bit, high whenever state != IDLE; biu.error, output, 1 bit, one-cycle pulse on read timeout.

Function
REQ-015 SHALL implement a one-hot FSM with states IDLE, SEND_REQ, WAIT_WR, WAIT_RSP, DONE.
REQ-016 In IDLE with biu.en=1, SHALL register biu.address, biu.data_in and biu.rnw into address_q, wdata_q and rnw_q and go to SEND_REQ; with biu.en=0, SHALL stay in IDLE.
REQ-017 In SEND_REQ, SHALL drive {bus.address, bus.data, bus.control} = {address_q, wdata_q, rnw_q, 1'b1} for exactly one cycle.
REQ-018 From SEND_REQ, SHALL go to WAIT_RSP if rnw_q=1, else to WAIT_WR.
REQ-019 In IDLE, WAIT_WR, WAIT_RSP and DONE, SHALL drive all bus signals to 'bz, so the bus is released the cycle after the request and the responder can drive it.
REQ-020 WAIT_WR SHALL last exactly one cycle (the responder's turnaround cycle) and then go to IDLE; write completion SHALL not pulse biu.data_valid.
REQ-021 In WAIT_RSP, when bus.control[0]=1, bus.control[1]=1 and bus.address==address_q, SHALL capture bus.data into biu.data_out and go to DONE.
REQ-022 In WAIT_RSP, SHALL ignore bus cycles with control[0]=0 (responder busy).
REQ-023 In DONE, SHALL assert biu.data_valid for exactly one cycle and then go to IDLE.
REQ-024 SHALL have a 16-bit timeout counter, cleared on entry to WAIT_RSP and incremented each WAIT_RSP cycle without a matching response.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 with no response, SHALL pulse biu.error for one cycle, leave biu.data_out unchanged and go to IDLE.
REQ-026 If a response and the timeout occur in the same cycle, SHALL give the response priority (no error).
REQ-027 SHALL ignore biu.en while busy; it SHALL not queue requests.
REQ-028 The earliest next request SHALL be accepted in the cycle busy falls.
REQ-029 Minimum latency SHALL be 3 cycles for a write (en->IDLE) and 4 cycles for a read (en->data_valid), given a responder that answers one cycle after the request.

Reset
REQ-030 On n_rst=0, SHALL immediately set state=IDLE, address_q=0, wdata_q=0, rnw_q=0, biu.data_out=0 and timeout counter=0.
REQ-031 On n_rst=0, SHALL immediately drive biu.data_valid=0, biu.error=0 and biu.busy=0 and release the bus to 'bz.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no data_valid or error pulse.

Verification
REQ-033 Write test: en=1, rnw=0, addr=0x100, data=0xDEADBEEF -> bus shows 0x100/0xDEADBEEF/control=2'b01 for 1 cycle, bus is Z afterwards, busy is high 2 cycles, no data_valid.
REQ-034 Read test: en=1, rnw=1, addr=0x104; responder drives control=2'b10 for 2 cycles, then 2'b11 with data 0x12345678 -> data_out=0x12345678 and a single data_valid pulse.
REQ-035 Timeout test: read with TIMEOUT_CYCLES=4 and no responder -> error pulses after 4 WAIT_RSP cycles, data_out is unchanged, FSM returns to IDLE.
REQ-036 Mismatch test: during a read, a response arrives with a different address -> it is ignored; a later matching response is captured.
REQ-037 Busy test: en held high during a read -> only one request is issued until busy falls, then the next request goes out.
REQ-038 Reset test: n_rst pulsed low during WAIT_RSP -> all outputs go to reset values asynchronously, the bus is Z, and there is no data_valid or error pulse.
